// File: rtl/vec_exec_ctrl_pkg.sv
// Shared definitions for the vector execution issue controller.
// Holds the FSM state encoding, EU operation codes and the multiply timeout limit.
// MAX_VLEN defaults to 128 bits when not supplied by the build.
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

package vec_exec_ctrl_pkg;

  // Controller states: accept, single-cycle execute, multiply wait, writeback hold.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_WAIT = 2'd2,
    WB       = 2'd3
  } state_t;

  // Operation codes presented on issue_op and forwarded on eu_execution_op.
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_IDLE  = 3'b111;

  // Number of MUL_WAIT cycles tolerated before the watchdog aborts a multiply.
  localparam logic [7:0] MUL_TIMEOUT = 8'd255;

  // Only add, shift and multiply launch the execution unit.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SHIFT) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/vec_exec_watchdog.sv
// Multiply watchdog: counts enabled cycles and flags the last tolerated one.
// Latency: expired is combinational on the MUL_TIMEOUT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

module vec_exec_watchdog
  import vec_exec_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] r_cnt;

  // Count cycles spent waiting; saturate so a stuck enable cannot wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= 8'd0;
    end else if (enable && (r_cnt != MUL_TIMEOUT)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // r_cnt holds the number of completed wait cycles, so the current cycle is r_cnt+1.
  assign expired = enable && (r_cnt == (MUL_TIMEOUT - 8'd1));

endmodule

// File: rtl/vector_exec_issue_ctrl.sv
// Issue controller sequencing one vector op at a time through the EU to writeback.
// Latency: add/shift handshake N -> wb_valid N+2; mul -> wb_valid one cycle after count_0 is taken.
// Backpressure: holds WB until wb_ready; issue_ready only in IDLE. VEC_EXEC_TIMEOUT_EN adds a mul watchdog.
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

module vector_exec_issue_ctrl
  import vec_exec_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  // issue side
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           issue_op,
  input  logic [6:0]           issue_sew,
  input  logic [`MAX_VLEN-1:0] issue_vs1_data,
  input  logic [`MAX_VLEN-1:0] issue_vs2_data,
  input  logic                 issue_sub,
  input  logic                 issue_rsub,
  input  logic                 issue_signed,
  input  logic                 issue_mul_high,
  input  logic [4:0]           issue_vd,
  // execution-unit side
  output logic [`MAX_VLEN-1:0] eu_data_1,
  output logic [`MAX_VLEN-1:0] eu_data_2,
  output logic                 eu_ctrl,
  output logic                 eu_signed_mode,
  output logic                 eu_mul_low,
  output logic                 eu_mul_high,
  output logic                 eu_reverse_sub,
  output logic [6:0]           eu_sew,
  output logic [2:0]           eu_execution_op,
  input  logic [`MAX_VLEN-1:0] eu_result,
  input  logic                 eu_count_0,
  // writeback side
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [`MAX_VLEN-1:0] wb_data,
  output logic [4:0]           wb_vd,
  output logic                 busy,
  output logic                 err_illegal
);

  state_t               r_state;
  state_t               w_next_state;

  logic [2:0]           r_op;
  logic [6:0]           r_sew;
  logic [`MAX_VLEN-1:0] r_vs1;
  logic [`MAX_VLEN-1:0] r_vs2;
  logic                 r_sub;
  logic                 r_rsub;
  logic                 r_signed;
  logic                 r_mul_high;
  logic [4:0]           r_vd;
  logic [`MAX_VLEN-1:0] r_wb_data;
  logic                 r_err;
  logic                 r_mul_first;

  logic                 w_launch;
  logic                 w_illegal;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_eu_active;
  logic                 w_wd_expired;

`ifdef VEC_EXEC_TIMEOUT_EN
  logic                 w_wd_enable;
  logic                 w_wd_clear;

  // The watchdog only runs while a multiply is outstanding and restarts on every new one.
  assign w_wd_enable = (r_state == MUL_WAIT);
  assign w_wd_clear  = ~w_wd_enable;

  vec_exec_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );
`else
  // Without the watchdog a multiply waits for count_0 indefinitely.
  assign w_wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection, handshake decode and all state-dependent outputs.
  always_comb begin
    w_next_state    = r_state;
    issue_ready     = 1'b0;
    busy            = 1'b1;
    wb_valid        = 1'b0;
    w_launch        = 1'b0;
    w_illegal       = 1'b0;
    w_capture       = 1'b0;
    w_timeout       = 1'b0;
    w_eu_active     = 1'b0;
    eu_data_1       = '0;
    eu_data_2       = '0;
    eu_ctrl         = 1'b0;
    eu_signed_mode  = 1'b0;
    eu_mul_low      = 1'b0;
    eu_mul_high     = 1'b0;
    eu_reverse_sub  = 1'b0;
    eu_sew          = 7'd0;
    eu_execution_op = OP_IDLE;

    case (r_state)
      IDLE: begin
        issue_ready = 1'b1;
        busy        = 1'b0;
        if (issue_valid) begin
          if (op_is_legal(issue_op)) begin
            w_launch     = 1'b1;
            w_next_state = (issue_op == OP_MUL) ? MUL_WAIT : EXEC;
          end else begin
            // Illegal ops are consumed and reported but never reach the EU.
            w_illegal = 1'b1;
          end
        end
      end
      EXEC: begin
        w_eu_active  = 1'b1;
        w_capture    = 1'b1;
        w_next_state = WB;
      end
      MUL_WAIT: begin
        w_eu_active = 1'b1;
        // count_0 may still be high from the previous multiply in the launch cycle.
        if (!r_mul_first && eu_count_0) begin
          w_capture    = 1'b1;
          w_next_state = WB;
        end else if (w_wd_expired) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (w_eu_active) begin
      eu_data_1       = r_rsub ? r_vs2 : r_vs1;
      eu_data_2       = r_rsub ? r_vs1 : r_vs2;
      eu_ctrl         = r_sub | r_rsub;
      eu_reverse_sub  = r_rsub;
      eu_signed_mode  = r_signed;
      eu_mul_high     = r_mul_high;
      eu_mul_low      = (r_op == OP_MUL) & ~r_mul_high;
      eu_sew          = r_sew;
      eu_execution_op = r_op;
    end
  end

  // Operand capture at launch, result capture at completion, error pulse generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_IDLE;
      r_sew       <= 7'd0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_sub       <= 1'b0;
      r_rsub      <= 1'b0;
      r_signed    <= 1'b0;
      r_mul_high  <= 1'b0;
      r_vd        <= 5'd0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_mul_first <= 1'b0;
    end else begin
      r_err       <= w_illegal | w_timeout;
      r_mul_first <= w_launch && (issue_op == OP_MUL);
      if (w_launch) begin
        r_op       <= issue_op;
        r_sew      <= issue_sew;
        r_vs1      <= issue_vs1_data;
        r_vs2      <= issue_vs2_data;
        r_sub      <= issue_sub;
        r_rsub     <= issue_rsub;
        r_signed   <= issue_signed;
        r_mul_high <= issue_mul_high;
        r_vd       <= issue_vd;
      end
      if (w_capture) begin
        r_wb_data <= eu_result;
      end
    end
  end

  assign wb_data     = r_wb_data;
  assign wb_vd       = r_vd;
  assign err_illegal = r_err;

endmodule

// File: doc/vector_exec_issue_ctrl.md
VECTOR_EXEC_ISSUE_CTRL -- requirements
Module: vector_exec_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge; reset  in  1  synchronous, active-high.
REQ-002 SHALL have issue side: issue_valid in 1; issue_ready out 1; issue_op in 3 (000 add, 001 shift, 011 mul); issue_sew in 7 (sew/eew code); issue_vs1_data, issue_vs2_data in `MAX_VLEN; issue_sub, issue_rsub, issue_signed, issue_mul_high in 1; issue_vd in 5.
REQ-003 SHALL have execution-unit side: eu_data_1, eu_data_2 out `MAX_VLEN; eu_ctrl, eu_signed_mode, eu_mul_low, eu_mul_high, eu_reverse_sub out 1; eu_sew out 7; eu_execution_op out 3; eu_result in `MAX_VLEN; eu_count_0 in 1 (multiply done).
REQ-004 SHALL have writeback side: wb_valid out 1; wb_ready in 1; wb_data out `MAX_VLEN; wb_vd out 5; plus busy out 1, err_illegal out 1 (one-cycle pulse).

Function
REQ-005 SHALL implement FSM states IDLE, EXEC, MUL_WAIT, WB.
REQ-006 issue_ready SHALL be 1 only in IDLE; handshake = issue_valid & issue_ready.
REQ-007 On handshake with op 000/001: all issue fields registered; next state EXEC.
REQ-008 On handshake with op 011: fields registered; next state MUL_WAIT.
REQ-009 On handshake with any other op: no EU launch, err_illegal pulses next cycle, stays IDLE, no writeback.
REQ-010 eu_* outputs SHALL drive registered fields in EXEC and MUL_WAIT; in IDLE and WB eu_data_1/2 = 0, eu_execution_op = 3'b111, all eu_* 1-bit = 0.
REQ-011 eu_ctrl = issue_sub | issue_rsub; when issue_rsub = 1, eu_data_1 = vs2 and eu_data_2 = vs1, else eu_data_1 = vs1, eu_data_2 = vs2.
REQ-012 eu_mul_high = registered issue_mul_high; eu_mul_low = its inverse (mul only).
REQ-013 EXEC lasts exactly one cycle; eu_result captured into wb_data at its end; next WB.
REQ-014 MUL_WAIT SHALL ignore eu_count_0 in its first cycle; from second cycle, eu_count_0 = 1 captures eu_result and moves to WB.
REQ-015 Latency: add/shift handshake at cycle N -> wb_valid at N+2; mul -> wb_valid the cycle after count_0 sampled.
REQ-016 WB: wb_valid = 1, wb_data/wb_vd stable until wb_valid & wb_ready; then IDLE. No new issue accepted in the same cycle (back-to-back throughput max 1 op / 3 cycles).
REQ-017 busy = 1 in every state except IDLE.

Reset
REQ-018 reset in any state (including mid-multiply) SHALL force IDLE next cycle; wb_valid, err_illegal, busy, wb_data, wb_vd, all eu_* = 0 (eu_execution_op = 3'b111); issue_ready = 1 the first cycle after reset deasserts.
REQ-019 An in-flight operation aborted by reset SHALL produce no writeback.

Configuration
REQ-020 Macro VEC_EXEC_TIMEOUT_EN defined: 8-bit watchdog counts MUL_WAIT cycles; at 255 without count_0, FSM returns to IDLE, err_illegal pulses, no writeback.
REQ-021 Macro undefined: no watchdog; MUL_WAIT waits indefinitely.

Structure
REQ-022 State enum, op encodings (OP_ADD, OP_SHIFT, OP_MUL, OP_IDLE = 3'b111) and MUL_TIMEOUT = 255 SHALL live in shared package vec_exec_ctrl_pkg.
REQ-023 Watchdog SHALL be sub-module vec_exec_watchdog (clear, enable, expired), instantiated only under VEC_EXEC_TIMEOUT_EN.

Verification
REQ-024 Add: vs1=5, vs2=3 per lane, sub=0, wb_ready=1 -> eu_ctrl=0 in EXEC; wb_valid at N+2, wb_data = EU result.
REQ-025 Rsub: vs1=5, vs2=3, rsub=1 -> eu_data_1=3, eu_data_2=5, eu_ctrl=1.
REQ-026 Mul: count_0 held high from launch, then drops and reasserts 4 cycles later -> first-cycle count_0 ignored; wb_valid one cycle after sampled assertion; mul_high=1 -> eu_mul_low=0.
REQ-027 Backpressure: wb_ready=0 for 10 cycles -> wb_valid/wb_data stable, issue_ready=0, issue_valid ignored.
REQ-028 issue_op=3'b010 -> err_illegal one-cycle pulse, no wb_valid, issue_ready stays 1.
REQ-029 reset asserted in MUL_WAIT cycle 3 -> IDLE, no wb_valid ever; with VEC_EXEC_TIMEOUT_EN and count_0 stuck 0 -> abort plus err_illegal after 255 cycles.
